input_buffer_b2_ctrl: RTL and testbench
=======================================

# input_buffer_b2_ctrl

Sequencer for the block-2 input buffer: eight single-port banks, each 32 bits wide and 29 entries deep. It owns every bank port. It fills the banks from a 32-bit activation stream, channel-interleaved. It then drains them as 29 parallel 8×32-bit beats toward the block-2 PE array, and applies back-pressure in both directions.

## Interface
Parameters:
- NUM_BANKS, 8, number of buffer banks
- DATA_WIDTH, 32, bank word width
- ADDR_WIDTH, 5, bank address width
- DEPTH, 29, valid entries per bank; the fill length is NUM_BANKS*DEPTH = 232 words

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- wr_start  in  1  starts a fill; accepted only in IDLE
- in_data  in  32  stream word
- in_valid  in  1  stream word valid
- in_ready  out  1  stream ready
- rd_start  in  1  starts a drain; accepted only in FULL
- out_data  out  256  beat; bank b occupies bits [32b+31:32b]
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- bank_din  out  256  per-bank write data, packed like out_data
- bank_addr  out  40  per-bank address, 5 bits per bank
- bank_we  out  8  per-bank write enable
- bank_en  out  8  per-bank enable
- bank_dout  in  256  per-bank read data; one-cycle latency; holds its value while en is low
- fill_done  out  1  one-cycle pulse when the 232nd word is written
- drain_done  out  1  one-cycle pulse when the 29th beat is accepted
- busy  out  1  high in FILL and DRAIN

## Operation
- **States:** IDLE, FILL, FULL, DRAIN.
  - IDLE to FILL on wr_start.
  - FILL to FULL after the last word is accepted.
  - FULL to DRAIN on rd_start.
  - DRAIN to IDLE when the last beat handshakes.
  - wr_start outside IDLE and rd_start outside FULL are ignored.
- **Fill:**
  - in_ready = (state==FILL).
  - Accepted word k (0..231) is written to bank k%8 at address k/8.
  - Counters: a 3-bit bank counter and an address counter. The bank counter wraps 7 to 0 and increments the address.
  - On the acceptance with bank=7 and addr=DEPTH-1, the FSM moves to FULL.
- **Drain:**
  - A read is issued when state==DRAIN, rd_addr<DEPTH, and (!out_valid || out_ready).
  - Issuing a read sets bank_en to all ones, bank_we to zero, and all bank addresses to rd_addr; rd_addr then increments.
  - out_data is wired directly from bank_dout.
  - out_valid rises in the cycle after an issue. It stays high until handshake and is refreshed if a new read was issued in the same cycle.
  - While stalled, bank_en stays low, so bank_dout and out_data hold.
- **Width rule:** counters are ADDR_WIDTH bits. rd_addr saturates at DEPTH, and a read is never issued at address DEPTH or above.
- **Idle bank ports:** outside write and read cycles, bank_en, bank_we, bank_addr and bank_din are zero.
- **Reset:** reset mid-fill or mid-drain returns the FSM to IDLE and zeroes all counters and outputs. Bank contents are not cleared. A new fill overwrites all 232 entries.

## Timing
- Reset values are zero for in_ready, out_valid, bank_en, bank_we, bank_addr, bank_din, fill_done, drain_done and busy.
- **Write latency:**
  - Bank write signals are registered: a word accepted in cycle t drives en and we on its bank during cycle t+1.
  - fill_done pulses in cycle t+1 of the final acceptance.
  - in_ready is low from cycle t+1.
- **Fill throughput:** one word per cycle, so an unthrottled fill takes 232 cycles.
- **Read latency:**
  - rd_start in FULL (cycle t) puts the FSM in DRAIN at t+1, with the first read issued at t+1.
  - The first out_valid is at t+2.
  - With out_ready held high, the drain streams 29 beats on consecutive cycles. drain_done pulses in the cycle after the final handshake, together with the return to IDLE.
- **Simultaneous events:** a handshake and a new issue in the same cycle keep out_valid high with no bubble. rst overrides everything.

## Structure
- A shared package holds NUM_BANKS, DATA_WIDTH, ADDR_WIDTH, DEPTH, the FSM state encoding, and the bank-slice index helpers.
- The controller is a single module, instantiated alongside the eight-bank buffer and connected port-for-port.
- The 1-deep hold logic on out_valid is the only natural sub-block, named drain_stage. It is optional to split out.

## Test plan
- **Full fill:** wr_start, then 232 words with in_data=k and in_valid always high.
  - Each write shows bank k%8, address k/8, data k one cycle after acceptance.
  - fill_done pulses exactly once; in_ready falls after the 232nd word.
- **Unthrottled drain:** rd_start with out_ready=1.
  - Beat a carries bank b equal to 8a+b, for a=0..28.
  - Beats arrive on 29 consecutive cycles, with the first out_valid 2 cycles after rd_start.
  - drain_done pulses, and the FSM returns to IDLE.
- **Stalled drain:** out_ready toggles with pattern 1,0,0,1.
  - out_data stays stable while stalled, and bank_en is low during stalls.
  - No beat is lost or duplicated; the total is 29 beats.
- **Throttled input:** in_valid random at 30%.
  - Bank contents are identical to the full-fill case, and no writes occur without a handshake.
- **Ignored starts:** rd_start in IDLE or FILL, and wr_start in FULL or DRAIN.
  - No state change, and bank ports remain idle.
- **Reset mid-operation:** rst asserted at word 100 of a fill, then a fresh full fill and drain.
  - All outputs are zero in the cycle after rst.
  - The fresh drain returns the new data only.

Source files
------------

// File: rtl/input_buffer_b2_ctrl_pkg.sv
// Shared definitions for the block-2 input buffer sequencer.
// Holds the buffer geometry, the FSM state encoding and the helpers that
// locate one bank's slice inside the packed per-bank port vectors.
package input_buffer_b2_ctrl_pkg;

  localparam int IB_NUM_BANKS  = 8;
  localparam int IB_DATA_WIDTH = 32;
  localparam int IB_ADDR_WIDTH = 5;
  localparam int IB_DEPTH      = 29;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // LSB of bank b's field in a vector packed as {bank N-1, ..., bank 0}.
  function automatic int slice_lsb(input int b, input int w);
    return b * w;
  endfunction

endpackage

// File: rtl/input_buffer_b2_ctrl_drain_stage.sv
// One-deep output hold for the drain path.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   issue      - a bank read is being launched this cycle
//   out_ready  - consumer ready
//   out_valid  - read data on bank_dout is a live beat
//   hs         - beat handshake this cycle
// The bank itself is the data register: read data stays on bank_dout until
// the next read, so only the valid bit needs holding here.
module input_buffer_b2_ctrl_drain_stage (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic out_ready,
  output logic out_valid,
  output logic hs
);

  logic vld_q;

  assign out_valid = vld_q;
  assign hs        = vld_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst)            vld_q <= 1'b0;
    else if (issue)     vld_q <= 1'b1;  // new beat replaces the one leaving
    else if (hs)        vld_q <= 1'b0;
  end

endmodule

// File: rtl/input_buffer_b2_ctrl.sv
// Block-2 input buffer sequencer.
// Fills eight single-port banks from a channel-interleaved word stream
// (word k -> bank k%8, address k/8), then drains them as DEPTH parallel
// beats of NUM_BANKS words each.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   wr_start / rd_start        - start fill (from IDLE) / drain (from FULL)
//   in_data/in_valid/in_ready  - fill stream
//   out_data/out_valid/out_ready - drain beats, out_data = bank_dout
//   bank_din/addr/we/en/dout   - packed per-bank port bundle
//   fill_done/drain_done       - one-cycle completion pulses
//   busy                       - FILL or DRAIN in progress
module input_buffer_b2_ctrl
  import input_buffer_b2_ctrl_pkg::*;
#(
  parameter int NUM_BANKS  = IB_NUM_BANKS,
  parameter int DATA_WIDTH = IB_DATA_WIDTH,
  parameter int ADDR_WIDTH = IB_ADDR_WIDTH,
  parameter int DEPTH      = IB_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_start,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             rd_start,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_din,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0]  bank_addr,
  output logic [NUM_BANKS-1:0]             bank_we,
  output logic [NUM_BANKS-1:0]             bank_en,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_dout,
  output logic                             fill_done,
  output logic                             drain_done,
  output logic                             busy
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BW-1:0]         LAST_B  = BW'(NUM_BANKS - 1);

  state_e                          state_q;
  logic [BW-1:0]                   bank_q;
  logic [ADDR_WIDTH-1:0]           wr_addr_q;
  logic [ADDR_WIDTH-1:0]           rd_addr_q;
  logic [NUM_BANKS-1:0]            wen_q;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] waddr_q;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wdin_q;
  logic                            fill_done_q, drain_done_q;

  logic accept, last_word, issue, hs, last_beat;

  assign accept    = (state_q == S_FILL) && in_valid;
  assign last_word = accept && (bank_q == LAST_B) && (wr_addr_q == LAST_A);
  // rd_addr stops at DEPTH; the compare keeps reads off addresses >= DEPTH.
  assign issue     = (state_q == S_DRAIN) && (rd_addr_q < DEPTH_A) &&
                     (!out_valid || out_ready);
  // Once rd_addr has reached DEPTH the beat in flight is the final one.
  assign last_beat = (state_q == S_DRAIN) && hs && (rd_addr_q == DEPTH_A);

  input_buffer_b2_ctrl_drain_stage u_drain_stage (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .hs        (hs)
  );

  assign in_ready   = (state_q == S_FILL);
  assign busy       = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign out_data   = bank_dout;
  assign fill_done  = fill_done_q;
  assign drain_done = drain_done_q;

  // Writes come from registers (one cycle after acceptance); reads are
  // launched combinationally so data lands one cycle after issue. The two
  // never overlap: the last write drains out while the FSM sits in FULL.
  always_comb begin
    bank_en   = wen_q;
    bank_we   = wen_q;
    bank_addr = waddr_q;
    bank_din  = wdin_q;
    if (issue) begin
      bank_en   = '1;
      bank_we   = '0;
      bank_addr = {NUM_BANKS{rd_addr_q}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bank_q       <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wen_q        <= '0;
      waddr_q      <= '0;
      wdin_q       <= '0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      wen_q        <= '0;
      waddr_q      <= '0;
      wdin_q       <= '0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (wr_start) begin
          state_q   <= S_FILL;
          bank_q    <= '0;
          wr_addr_q <= '0;
        end
        S_FILL: if (accept) begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BW'(b)) begin
              wen_q[b] <= 1'b1;
              waddr_q[slice_lsb(b, ADDR_WIDTH) +: ADDR_WIDTH] <= wr_addr_q;
              wdin_q[slice_lsb(b, DATA_WIDTH) +: DATA_WIDTH]  <= in_data;
            end
          end
          if (last_word) begin
            state_q     <= S_FULL;
            fill_done_q <= 1'b1;
            bank_q      <= '0;
            wr_addr_q   <= '0;
          end else if (bank_q == LAST_B) begin
            bank_q    <= '0;
            wr_addr_q <= wr_addr_q + 1'b1;
          end else begin
            bank_q <= bank_q + 1'b1;
          end
        end
        S_FULL: if (rd_start) begin
          state_q   <= S_DRAIN;
          rd_addr_q <= '0;
        end
        S_DRAIN: begin
          if (issue) rd_addr_q <= rd_addr_q + 1'b1;
          if (last_beat) begin
            state_q      <= S_IDLE;
            drain_done_q <= 1'b1;
            rd_addr_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_buffer_b2_ctrl.sv
module tb_input_buffer_b2_ctrl;

  localparam int NB = 8, DW = 32, AW = 5, DEP = 29, NW = NB * DEP;

  logic clk = 1'b0;
  logic rst, wr_start, in_valid, rd_start, out_ready;
  logic [DW-1:0]    in_data;
  logic             in_ready, out_valid, fill_done, drain_done, busy;
  logic [NB*DW-1:0] out_data, bank_din, bank_dout;
  logic [NB*AW-1:0] bank_addr;
  logic [NB-1:0]    bank_we, bank_en;

  always #5 clk = ~clk;

  input_buffer_b2_ctrl dut (
    .clk(clk), .rst(rst), .wr_start(wr_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .rd_start(rd_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bank_din(bank_din), .bank_addr(bank_addr), .bank_we(bank_we),
    .bank_en(bank_en), .bank_dout(bank_dout), .fill_done(fill_done),
    .drain_done(drain_done), .busy(busy)
  );

  // Eight single-port banks, one-cycle read latency, dout held while en low.
  logic [DW-1:0] mem [NB][32];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem[b][bank_addr[b*AW +: AW]] <= bank_din[b*DW +: DW];
        else            bank_dout[b*DW +: DW] <= mem[b][bank_addr[b*AW +: AW]];
      end
    end
  end

  typedef struct { logic [2:0] bank; logic [4:0] addr; logic [31:0] data; } wr_t;
  wr_t          wq[$];
  logic [255:0] bq[$];

  int checks = 0, errors = 0;
  int fill_cnt = 0, drain_cnt = 0, beat_cnt = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, after stimulus.
  logic         prev_stall = 1'b0;
  logic [255:0] prev_data;
  always @(negedge clk) begin
    #1;
    if (|bank_we) begin
      if (wq.size() == 0) chk("spurious_write", {bank_we}, 0);
      else begin
        wr_t e;
        logic [NB-1:0]    xen;
        logic [NB*AW-1:0] xad;
        logic [NB*DW-1:0] xdi;
        e = wq.pop_front();
        xen = '0; xad = '0; xdi = '0;
        xen[e.bank] = 1'b1;
        xad[e.bank*AW +: AW] = e.addr;
        xdi[e.bank*DW +: DW] = e.data;
        chk("wr_en_we", {bank_en, bank_we}, {xen, xen});
        chk("wr_addr", bank_addr, xad);
        chk("wr_din", bank_din, xdi);
      end
    end
    if (prev_stall) chk("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
    if (out_valid && !out_ready) chk("stall_en_low", bank_en, 0);
    if (out_valid && out_ready) begin
      beat_cnt++;
      if (bq.size() == 0) chk("extra_beat", 1, 0);
      else chk("beat_data", out_data, bq.pop_front());
    end
    if (fill_done)  fill_cnt++;
    if (drain_done) drain_cnt++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  // Fill: word k carries k^xv; stop_at aborts early; poke pulses rd_start.
  task automatic fill(input logic [31:0] xv, input int pct, input int stop_at, input bit poke);
    int k = 0, g = 0;
    @(negedge clk); wr_start = 1'b1;
    @(negedge clk); wr_start = 1'b0;
    while (k < NW && k != stop_at && g < 5000) begin
      in_valid = (int'($urandom_range(0, 99)) < pct);
      in_data  = in_valid ? (32'(k) ^ xv) : 32'hDEADBEEF;
      rd_start = poke && (g == 20);
      if (poke && g == 21) chk("rd_start_in_fill", in_ready, 1);
      if (in_valid && in_ready) begin
        wq.push_back('{bank: 3'(k % 8), addr: 5'(k / 8), data: 32'(k) ^ xv});
        k++;
      end
      g++;
      @(negedge clk);
    end
    in_valid = 1'b0; rd_start = 1'b0;
    if (g >= 5000) chk("fill_timeout", 1, 0);
    if (stop_at < 0) begin
      if (pct >= 100) chk("fill_cycles", g, NW);
      #1;
      chk("fill_done_pulse", {fill_done, in_ready, busy}, 3'b100);
      @(negedge clk); #1;
      chk("fill_done_once", fill_done, 0);
    end
  endtask

  task automatic drain(input logic [31:0] xv, input bit stall);
    logic [255:0] bt;
    logic [3:0]   pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 0 first)
    int n = 0, g = 0;
    for (int a = 0; a < DEP; a++) begin
      for (int b = 0; b < NB; b++) bt[b*DW +: DW] = 32'(8 * a + b) ^ xv;
      bq.push_back(bt);
    end
    beat_cnt = 0;
    @(negedge clk); rd_start = 1'b1; out_ready = 1'b1;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("first_issue", {out_valid, bank_en, bank_we}, {1'b0, 8'hFF, 8'h00});
    if (!stall) begin
      @(negedge clk); #1;
      chk("first_valid", out_valid, 1);
      for (int i = 1; i < DEP; i++) begin
        @(negedge clk); #1;
        if (out_valid) n++;
      end
      chk("consecutive_beats", n, DEP - 1);
      @(negedge clk); #1;
      chk("drain_done_pulse", {drain_done, busy, out_valid}, 3'b100);
      @(negedge clk); #1;
      chk("drain_done_once", drain_done, 0);
    end else begin
      while (!drain_done && g < 500) begin
        @(negedge clk);
        out_ready = pat[g % 4];
        wr_start  = (g == 10);
        #1;
        if (g == 11) chk("wr_start_in_drain", {in_ready, busy}, 2'b01);
        g++;
      end
      wr_start = 1'b0;
      chk("stall_drain_end", {drain_done, busy}, 2'b10);
    end
    chk("beat_count", beat_cnt, DEP);
    chk("beats_left", bq.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_start = 1'b0; in_valid = 1'b0; rd_start = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctl", {in_ready, out_valid, fill_done, drain_done, busy}, 0);
    chk("reset_bank", {bank_en, bank_we, bank_addr}, 0);
    chk("reset_din", bank_din, 0);
    @(negedge clk); rst = 1'b0;

    // rd_start in IDLE is ignored
    @(negedge clk); rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("rd_start_in_idle", {busy, in_ready, out_valid, bank_en}, 0);

    // full fill (rd_start poked mid-fill), wr_start in FULL ignored, drain
    fill(32'h0, 100, -1, 1'b1);
    @(negedge clk); wr_start = 1'b1;
    @(negedge clk); wr_start = 1'b0; #1;
    chk("wr_start_in_full", {busy, in_ready, bank_en, bank_we, bank_addr}, 0);
    chk("wr_start_in_full_din", bank_din, 0);
    drain(32'h0, 1'b0);

    // throttled fill, same contents, stalled drain
    fill(32'h0, 30, -1, 1'b0);
    drain(32'h0, 1'b1);

    // reset at word 100, then fresh fill and drain with new data
    fill(32'h00AB0000, 100, 100, 1'b0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_fill_ctl", {in_ready, out_valid, fill_done, drain_done, busy}, 0);
    chk("rst_mid_fill_bank", {bank_en, bank_we, bank_addr}, 0);
    chk("rst_mid_fill_din", bank_din, 0);
    chk("rst_writes_left", wq.size(), 0);
    @(negedge clk); rst = 1'b0;
    fill(32'h3C000000, 100, -1, 1'b0);
    drain(32'h3C000000, 1'b0);

    repeat (3) @(negedge clk);
    chk("fill_done_total", fill_cnt, 3);
    chk("drain_done_total", drain_cnt, 3);
    chk("writes_left", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
